// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared core definitions for the writeback stage. It holds the LSU load
//   opcodes carried from MEM and the state type of the load-data FSM.
//   Contents:
//     LD_B / LD_H / LD_W / LD_BU / LD_HU : 4-bit LSU load opcodes
//     wb_state_t                         : EMPTY / FRESH / HELD
package writeback_stage_pkg;

    localparam logic [3:0] LD_B  = 4'b0000;
    localparam logic [3:0] LD_H  = 4'b0001;
    localparam logic [3:0] LD_W  = 4'b0010;
    localparam logic [3:0] LD_BU = 4'b1000;
    localparam logic [3:0] LD_HU = 4'b1001;

    // EMPTY: no load in WB.
    // FRESH: the load's SRAM data is on sram_rd_data this cycle.
    // HELD : the load stalled past its data cycle, so use the hold register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   MEM -> WB instruction bus.
//   Modports:
//     master : MEM side, drives every signal
//     slave  : WB side, samples every signal
//   Signals:
//     in_valid      MEM holds a valid instruction
//     in_pc/in_inst instruction PC and encoding
//     in_rw_en      register write enable
//     in_rw_addr    destination register
//     in_rw_data    result, or the byte address for loads
//     in_ram_rd_en  instruction is a load
//     in_lsu_op     LSU opcode
interface writeback_stage_if;

    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic [31:0] in_rw_data;
    logic        in_ram_rd_en;
    logic [3:0]  in_lsu_op;

    modport master (
        output in_valid, in_pc, in_inst, in_rw_en, in_rw_addr,
               in_rw_data, in_ram_rd_en, in_lsu_op
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_rw_en, in_rw_addr,
               in_rw_data, in_ram_rd_en, in_lsu_op
    );

endinterface

// File: rtl/writeback_stage_load_aligner.sv
// load_aligner
//   Combinational extractor and extender for load data.
//   Ports:
//     word       in  32  word-aligned memory data
//     offset     in  2   byte offset within the word
//     lsu_op     in  4   LSU load opcode
//     data       out 32  aligned and extended load result
//     misaligned out 1   halfword at offset 3, or word at a nonzero offset
module load_aligner
    import writeback_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [3:0]  lsu_op,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    // Offset 3 is misaligned for a halfword, so its lane choice does not matter.
    always_comb begin
        half_sel = word[15:0];
        case (offset)
            2'd0:    half_sel = word[15:0];
            2'd1:    half_sel = word[23:8];
            default: half_sel = word[31:16];
        endcase
    end

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (lsu_op)
            LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: data = {24'h0, byte_sel};
            LD_H: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = (offset == 2'd3);
            end
            LD_HU: begin
                data       = {16'h0, half_sel};
                misaligned = (offset == 2'd3);
            end
            LD_W: begin
                data       = word;
                misaligned = (offset != 2'd0);
            end
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Pipeline writeback register plus the load-data path. An instruction
//   captured from MEM retires (writes the register file) in the first
//   non-stalled cycle it sits in WB.
//   Optional feature: define DIFFTEST_EN to add the retirement trace ports.
//   Ports:
//     clk, rst_n            clock; asynchronous active-low reset
//     stall                 hold the WB register, no retirement this cycle
//     flush                 squash the instruction entering WB
//     mem                   MEM -> WB instruction bus (writeback_stage_if.slave)
//     sram_rd_data          read data, valid one cycle after MEM issued the read
//     rf_we/rf_waddr/rf_wdata  register-file write port
//     wb_commit/wb_pc/wb_inst  retirement trace (DIFFTEST_EN only)
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    writeback_stage_if.slave        mem,
    input  logic [31:0]             sram_rd_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata
`ifdef DIFFTEST_EN
    ,
    output logic                    wb_commit,
    output logic [31:0]             wb_pc,
    output logic [31:0]             wb_inst
`endif
);

    logic        valid;
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [31:0] rw_data;
    logic        ram_rd_en;
    logic [3:0]  lsu_op;
    logic [31:0] hold_data;

    wb_state_t   state;
    wb_state_t   state_next;

    logic        new_load;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic        misaligned;

    // A load enters WB only on a non-stalled edge and only when it survives the flush.
    assign new_load = ~stall & mem.in_valid & ~flush & mem.in_ram_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            rw_en     <= 1'b0;
            rw_addr   <= 5'd0;
            rw_data   <= 32'd0;
            ram_rd_en <= 1'b0;
            lsu_op    <= 4'd0;
        end else if (!stall) begin
            valid     <= mem.in_valid & ~flush;
            rw_en     <= mem.in_rw_en;
            rw_addr   <= mem.in_rw_addr;
            rw_data   <= mem.in_rw_data;
            ram_rd_en <= mem.in_ram_rd_en;
            lsu_op    <= mem.in_lsu_op;
        end
    end

`ifdef DIFFTEST_EN
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= 32'd0;
            inst_q <= 32'd0;
        end else if (!stall) begin
            pc_q   <= mem.in_pc;
            inst_q <= mem.in_inst;
        end
    end

    assign wb_commit = valid & ~stall;
    assign wb_pc     = pc_q;
    assign wb_inst   = inst_q;
`else
    logic unused_trace;
    assign unused_trace = ^{mem.in_pc, mem.in_inst};
`endif

    // Load-data FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Load-data FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:       state_next = new_load ? FRESH : EMPTY;
            FRESH, HELD: begin
                if (stall)         state_next = HELD;
                else if (new_load) state_next = FRESH;
                else               state_next = EMPTY;
            end
            default:     state_next = EMPTY;
        endcase
    end

    // Load-data FSM: output. SRAM data is only valid in the FRESH cycle, so
    // later stalled cycles read the copy captured during FRESH.
    always_comb begin
        load_word = sram_rd_data;
        if (state == HELD) load_word = hold_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              hold_data <= 32'd0;
        else if (state == FRESH) hold_data <= sram_rd_data;
    end

    load_aligner u_load_aligner (
        .word       (load_word),
        .offset     (rw_data[1:0]),
        .lsu_op     (lsu_op),
        .data       (load_data),
        .misaligned (misaligned)
    );

    // Gating with stall makes each instruction write exactly once, in its retiring cycle.
    assign rf_we    = valid & rw_en & (rw_addr != 5'd0) & ~stall
                      & ~(ram_rd_en & misaligned);
    assign rf_waddr = rw_addr;
    assign rf_wdata = ram_rd_en ? load_data : rw_data;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Directed self-checking bench for writeback_stage. Inputs are driven 1 ns
//   after a rising edge or on a falling edge. Outputs are sampled on the
//   falling edge. Define DIFFTEST_EN to also check the trace ports.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] sram_rd_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef DIFFTEST_EN
    logic        wb_commit;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
`endif

    int vectors;
    int miscompares;

    writeback_stage_if mem_bus ();

    writeback_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .mem          (mem_bus),
        .sram_rd_data (sram_rd_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
`ifdef DIFFTEST_EN
        ,
        .wb_commit    (wb_commit),
        .wb_pc        (wb_pc),
        .wb_inst      (wb_inst)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        mem_bus.in_valid     = 1'b0;
        mem_bus.in_pc        = 32'h0;
        mem_bus.in_inst      = 32'h0;
        mem_bus.in_rw_en     = 1'b0;
        mem_bus.in_rw_addr   = 5'd0;
        mem_bus.in_rw_data   = 32'h0;
        mem_bus.in_ram_rd_en = 1'b0;
        mem_bus.in_lsu_op    = 4'd0;
    endtask

    task automatic drive_alu(input logic [4:0] addr, input logic [31:0] data);
        mem_bus.in_valid     = 1'b1;
        mem_bus.in_pc        = 32'h0000_4000;
        mem_bus.in_inst      = 32'h0000_0013;
        mem_bus.in_rw_en     = 1'b1;
        mem_bus.in_rw_addr   = addr;
        mem_bus.in_rw_data   = data;
        mem_bus.in_ram_rd_en = 1'b0;
        mem_bus.in_lsu_op    = 4'd0;
    endtask

    task automatic drive_load(input logic [4:0] addr, input logic [31:0] byte_addr,
                              input logic [3:0] op);
        mem_bus.in_valid     = 1'b1;
        mem_bus.in_pc        = 32'h0000_5000;
        mem_bus.in_inst      = 32'h0000_0003;
        mem_bus.in_rw_en     = 1'b1;
        mem_bus.in_rw_addr   = addr;
        mem_bus.in_rw_data   = byte_addr;
        mem_bus.in_ram_rd_en = 1'b1;
        mem_bus.in_lsu_op    = op;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        sram_rd_data = 32'h0;
        drive_alu(5'd7, 32'h1234_5678);
        after_edge();
        after_edge();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_we got=%b exp=0", rf_we);
        end
        vectors++;
        if (rf_wdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_wdata got=%h exp=00000000", rf_wdata);
        end
        vectors++;
        if (dut.state !== EMPTY) begin
            miscompares++;
            $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state, EMPTY);
        end
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_we got=%b exp=0", rf_we);
        end
    endtask

    task automatic test_alu();
        drive_alu(5'd0, 32'd5);
        after_edge();
        drive_idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL alu_r0_we got=%b exp=0", rf_we);
        end
        drive_alu(5'd7, 32'd5);
        after_edge();
        drive_idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL alu_r7_we got=%b exp=1", rf_we);
        end
        vectors++;
        if (rf_waddr !== 5'd7) begin
            miscompares++;
            $display("[TB] FAIL alu_r7_waddr got=%0d exp=7", rf_waddr);
        end
        vectors++;
        if (rf_wdata !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL alu_r7_wdata got=%h exp=00000005", rf_wdata);
        end
        after_edge();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL alu_after_we got=%b exp=0", rf_we);
        end
    endtask

    // One load issued now; its SRAM word arrives in the following cycle.
    // Consecutive calls issue loads on consecutive edges.
    task automatic run_load(input string name, input logic [3:0] op, input logic [1:0] off,
                            input logic [31:0] word, input logic exp_we,
                            input logic [31:0] exp_data);
        drive_load(5'd3, {30'h0000_0800, off}, op);
        sram_rd_data = 32'h0BAD_F00D;
        after_edge();
        sram_rd_data = word;
        drive_idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== exp_we) begin
            miscompares++;
            $display("[TB] FAIL %s_we got=%b exp=%b", name, rf_we, exp_we);
        end
        if (exp_we) begin
            vectors++;
            if (rf_wdata !== exp_data) begin
                miscompares++;
                $display("[TB] FAIL %s_wdata got=%h exp=%h", name, rf_wdata, exp_data);
            end
        end
`ifdef DIFFTEST_EN
        vectors++;
        if (wb_commit !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_commit got=%b exp=1", name, wb_commit);
        end
`endif
    endtask

    task automatic test_back_to_back_loads();
        run_load("ldb_off3",  LD_B,  2'd3, 32'h8011_2233, 1'b1, 32'hFFFF_FF80);
        run_load("ldb_off0",  LD_B,  2'd0, 32'h8011_2233, 1'b1, 32'h0000_0033);
        run_load("ldbu_off1", LD_BU, 2'd1, 32'h8011_22A2, 1'b1, 32'h0000_0022);
        run_load("ldb_off2",  LD_B,  2'd2, 32'h80F1_2233, 1'b1, 32'hFFFF_FFF1);
        run_load("ldbu_off3", LD_BU, 2'd3, 32'h8011_2233, 1'b1, 32'h0000_0080);
        run_load("ldh_off0",  LD_H,  2'd0, 32'h9ABC_1234, 1'b1, 32'h0000_1234);
        run_load("ldh_off2",  LD_H,  2'd2, 32'h9ABC_1234, 1'b1, 32'hFFFF_9ABC);
        run_load("ldh_off1",  LD_H,  2'd1, 32'h9ABC_1234, 1'b1, 32'hFFFF_BC12);
        run_load("ldhu_off1", LD_HU, 2'd1, 32'h9ABC_1234, 1'b1, 32'h0000_BC12);
        run_load("ldw_off0",  LD_W,  2'd0, 32'h9ABC_1234, 1'b1, 32'h9ABC_1234);
        run_load("ldh_off3",  LD_H,  2'd3, 32'h9ABC_1234, 1'b0, 32'h0);
        run_load("ldw_off1",  LD_W,  2'd1, 32'h9ABC_1234, 1'b0, 32'h0);
        after_edge();
        @(negedge clk);
        vectors++;
        if (dut.state !== EMPTY) begin
            miscompares++;
            $display("[TB] FAIL loads_drain_state got=%0d exp=%0d", dut.state, EMPTY);
        end
    endtask

    task automatic test_stall_load();
        drive_load(5'd5, 32'h0000_0102, LD_HU);
        after_edge();
        sram_rd_data = 32'h9ABC_1234;
        stall = 1'b1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_cycle%0d_we got=%b exp=0", i, rf_we);
            end
            after_edge();
            sram_rd_data = 32'hDEAD_BEEF;
        end
        stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_release_we got=%b exp=1", rf_we);
        end
        vectors++;
        if (rf_wdata !== 32'h0000_9ABC) begin
            miscompares++;
            $display("[TB] FAIL stall_release_wdata got=%h exp=00009abc", rf_wdata);
        end
        vectors++;
        if (rf_waddr !== 5'd5) begin
            miscompares++;
            $display("[TB] FAIL stall_release_waddr got=%0d exp=5", rf_waddr);
        end
        after_edge();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_single_pulse_we got=%b exp=0", rf_we);
        end
    endtask

    task automatic test_flush();
        drive_alu(5'd9, 32'h55);
        flush = 1'b1;
        after_edge();
        flush = 1'b0;
        drive_idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_squash_we got=%b exp=0", rf_we);
        end
        drive_alu(5'd10, 32'h66);
        after_edge();
        stall = 1'b1;
        flush = 1'b1;
        drive_alu(5'd11, 32'h77);
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_stall_we got=%b exp=0", rf_we);
        end
        after_edge();
        stall = 1'b0;
        flush = 1'b0;
        drive_idle();
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_held_retire_we got=%b exp=1", rf_we);
        end
        vectors++;
        if (rf_waddr !== 5'd10) begin
            miscompares++;
            $display("[TB] FAIL flush_held_retire_waddr got=%0d exp=10", rf_waddr);
        end
        vectors++;
        if (rf_wdata !== 32'h66) begin
            miscompares++;
            $display("[TB] FAIL flush_held_retire_wdata got=%h exp=00000066", rf_wdata);
        end
        after_edge();
    endtask

    task automatic test_reset_in_held();
        drive_load(5'd12, 32'h0000_0200, LD_W);
        after_edge();
        sram_rd_data = 32'h1234_5678;
        stall = 1'b1;
        drive_idle();
        after_edge();
        @(negedge clk);
        vectors++;
        if (dut.state !== HELD) begin
            miscompares++;
            $display("[TB] FAIL held_state got=%0d exp=%0d", dut.state, HELD);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_reset_we got=%b exp=0", rf_we);
        end
        vectors++;
        if (dut.state !== EMPTY) begin
            miscompares++;
            $display("[TB] FAIL held_reset_state got=%0d exp=%0d", dut.state, EMPTY);
        end
        vectors++;
        if (dut.hold_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL held_reset_hold got=%h exp=00000000", dut.hold_data);
        end
        stall = 1'b0;
        after_edge();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL held_post_release%0d_we got=%b exp=0", i, rf_we);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive_idle();
        test_reset();
        test_alu();
        test_back_to_back_loads();
        test_stall_load();
        test_flush();
        test_reset_in_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
